// File: rtl/multiplier_pkg.sv
// Shared field widths, constants and FSM encoding for the single-precision
// floating-point multiplier and its operand classifier.
package multiplier_pkg;

  localparam int SIGN_W     = 1;
  localparam int EXP_W      = 8;
  localparam int FRAC_W     = 23;
  localparam int WORD_W     = SIGN_W + EXP_W + FRAC_W;
  localparam int SIG_W      = FRAC_W + 1;
  localparam int PROD_W     = 2 * SIG_W;
  localparam int EXP_CALC_W = EXP_W + 2;
  localparam int BIAS       = 127;

  localparam logic [WORD_W-1:0] QNAN     = 32'h7FC0_0000;
  localparam logic [EXP_W-1:0]  EXP_ONES = 8'hFF;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    NORM = 3'd2,
    RND  = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/multiplier_fp_classify.sv
// Decodes one single-precision operand into its class flags and fields.
// Zero and subnormal encodings are both reported as zero, significand cleared.
module fp_classify
  import multiplier_pkg::*;
(
  input  logic [WORD_W-1:0] operand,
  output logic              is_zero,
  output logic              is_inf,
  output logic              is_nan,
  output logic              sign,
  output logic [EXP_W-1:0]  exponent,
  output logic [SIG_W-1:0]  significand
);

  logic [FRAC_W-1:0] frac;

  always_comb begin
    sign        = operand[WORD_W-1];
    exponent    = operand[WORD_W-2 -: EXP_W];
    frac        = operand[FRAC_W-1:0];
    is_zero     = (exponent == '0);
    is_inf      = (exponent == EXP_ONES) && (frac == '0);
    is_nan      = (exponent == EXP_ONES) && (frac != '0);
    significand = is_zero ? '0 : {1'b1, frac};
  end

endmodule

// File: rtl/multiplier.sv
// Multi-cycle IEEE-754 single-precision multiplier: IDLE -> MUL -> NORM -> RND
// -> DONE, one result every five cycles, round-to-nearest-even, flush-to-zero.
module multiplier
  import multiplier_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] A,
  input  logic [WORD_W-1:0] B,
  input  logic              En,
  output logic [WORD_W-1:0] Result,
  output logic              Ready,
  output logic              NaN
);

  localparam logic signed [EXP_CALC_W-1:0] BIAS_S    = EXP_CALC_W'(BIAS);
  localparam logic signed [EXP_CALC_W-1:0] ONE_S     = EXP_CALC_W'(1);
  localparam logic signed [EXP_CALC_W-1:0] ZERO_S    = '0;
  localparam logic signed [EXP_CALC_W-1:0] EXP_OVF_S = EXP_CALC_W'(EXP_ONES);

  state_t state, state_next;
  logic   load_ops;

  logic [WORD_W-1:0] op_a, op_b;

  logic             a_zero, a_inf, a_nan, a_sign;
  logic             b_zero, b_inf, b_nan, b_sign;
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [SIG_W-1:0] a_sig, b_sig;

  logic                         spec_nan, spec_inf, spec_zero, sign_q;
  logic [PROD_W-1:0]            prod_q;
  logic signed [EXP_CALC_W-1:0] exp_mul_q;

  logic [SIG_W-1:0]             mant_q;
  logic                         guard_q, round_q, sticky_q;
  logic signed [EXP_CALC_W-1:0] exp_norm_q;

  logic [SIG_W-1:0]             mant_n;
  logic                         guard_n, round_n, sticky_n;
  logic signed [EXP_CALC_W-1:0] exp_norm_n;

  logic                         round_up;
  logic [SIG_W:0]               mant_rounded;
  logic [FRAC_W-1:0]            frac_final;
  logic signed [EXP_CALC_W-1:0] exp_final;
  logic [WORD_W-1:0]            result_n;
  logic                         nan_n;

  fp_classify u_class_a (
    .operand    (op_a),
    .is_zero    (a_zero),
    .is_inf     (a_inf),
    .is_nan     (a_nan),
    .sign       (a_sign),
    .exponent   (a_exp),
    .significand(a_sig)
  );

  fp_classify u_class_b (
    .operand    (op_b),
    .is_zero    (b_zero),
    .is_inf     (b_inf),
    .is_nan     (b_nan),
    .sign       (b_sign),
    .exponent   (b_exp),
    .significand(b_sig)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (En) state_next = MUL;
      MUL:     state_next = NORM;
      NORM:    state_next = RND;
      RND:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    load_ops = (state == IDLE) && En;
    Ready    = (state == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_a <= '0;
      op_b <= '0;
    end else if (load_ops) begin
      op_a <= A;
      op_b <= B;
    end
  end

  // Special-case classes are resolved here and carried alongside the datapath
  // so every operand class takes the same number of cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      spec_nan  <= 1'b0;
      spec_inf  <= 1'b0;
      spec_zero <= 1'b0;
      sign_q    <= 1'b0;
      prod_q    <= '0;
      exp_mul_q <= '0;
    end else if (state == MUL) begin
      spec_nan  <= a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero);
      spec_inf  <= a_inf || b_inf;
      spec_zero <= a_zero || b_zero;
      sign_q    <= a_sign ^ b_sign;
      prod_q    <= PROD_W'(a_sig) * PROD_W'(b_sig);
      exp_mul_q <= $signed(EXP_CALC_W'(a_exp)) + $signed(EXP_CALC_W'(b_exp)) - BIAS_S;
    end
  end

  always_comb begin
    if (prod_q[PROD_W-1]) begin
      mant_n     = prod_q[PROD_W-1 -: SIG_W];
      guard_n    = prod_q[PROD_W-SIG_W-1];
      round_n    = prod_q[PROD_W-SIG_W-2];
      sticky_n   = |prod_q[PROD_W-SIG_W-3:0];
      exp_norm_n = exp_mul_q + ONE_S;
    end else begin
      mant_n     = prod_q[PROD_W-2 -: SIG_W];
      guard_n    = prod_q[PROD_W-SIG_W-2];
      round_n    = prod_q[PROD_W-SIG_W-3];
      sticky_n   = |prod_q[PROD_W-SIG_W-4:0];
      exp_norm_n = exp_mul_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mant_q     <= '0;
      guard_q    <= 1'b0;
      round_q    <= 1'b0;
      sticky_q   <= 1'b0;
      exp_norm_q <= '0;
    end else if (state == NORM) begin
      mant_q     <= mant_n;
      guard_q    <= guard_n;
      round_q    <= round_n;
      sticky_q   <= sticky_n;
      exp_norm_q <= exp_norm_n;
    end
  end

  // A round-up that carries out of the mantissa leaves 1.000..0, so dropping
  // the low bit and bumping the exponent renormalises it.
  always_comb begin
    round_up     = guard_q && (round_q || sticky_q || mant_q[0]);
    mant_rounded = {1'b0, mant_q} + (SIG_W+1)'(round_up);
    if (mant_rounded[SIG_W]) begin
      frac_final = mant_rounded[FRAC_W:1];
      exp_final  = exp_norm_q + ONE_S;
    end else begin
      frac_final = mant_rounded[FRAC_W-1:0];
      exp_final  = exp_norm_q;
    end

    nan_n = 1'b0;
    if (spec_nan) begin
      result_n = QNAN;
      nan_n    = 1'b1;
    end else if (spec_inf) begin
      result_n = {sign_q, EXP_ONES, {FRAC_W{1'b0}}};
    end else if (spec_zero) begin
      result_n = {sign_q, {(WORD_W-1){1'b0}}};
    end else if (exp_final >= EXP_OVF_S) begin
      result_n = {sign_q, EXP_ONES, {FRAC_W{1'b0}}};
    end else if (exp_final <= ZERO_S) begin
      result_n = {sign_q, {(WORD_W-1){1'b0}}};
    end else begin
      result_n = {sign_q, exp_final[EXP_W-1:0], frac_final};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Result <= '0;
      NaN    <= 1'b0;
    end else if (state == RND) begin
      Result <= result_n;
      NaN    <= nan_n;
    end
  end

endmodule

// File: tb/tb_multiplier.sv
// Self-checking bench for the floating-point multiplier: directed corner
// products, randomized operands against an arithmetic reference, control tests.
module tb_multiplier;

  logic        clk = 1'b0;
  logic        reset;
  logic        En;
  logic [31:0] A, B;
  logic [31:0] Result;
  logic        Ready;
  logic        NaN;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_result;

  always #5 clk = ~clk;

  multiplier dut (
    .clk   (clk),
    .reset (reset),
    .A     (A),
    .B     (B),
    .En    (En),
    .Result(Result),
    .Ready (Ready),
    .NaN   (NaN)
  );

  localparam int N_DIR = 15;
  logic [31:0] dir_a   [N_DIR] = '{32'h3FC00000, 32'h40400000, 32'hBFC00000, 32'h00000000,
                                   32'h7F800000, 32'h7F800000, 32'h7FC00000, 32'h7F7FFFFF,
                                   32'h00800000, 32'h3F800001, 32'h3F800001, 32'h3F800002,
                                   32'hFF800000, 32'h00400000, 32'h7F800000};
  logic [31:0] dir_b   [N_DIR] = '{32'h40200000, 32'hBFA00000, 32'hC0000000, 32'hC0A00000,
                                   32'h3FC00000, 32'h00000000, 32'h40000000, 32'h40000000,
                                   32'h00800000, 32'h3F800001, 32'h3FC00000, 32'h3FA00000,
                                   32'h3F800000, 32'hBF800000, 32'hC0000000};
  logic [31:0] dir_res [N_DIR] = '{32'h40700000, 32'hC0700000, 32'h40400000, 32'h80000000,
                                   32'h7F800000, 32'h7FC00000, 32'h7FC00000, 32'h7F800000,
                                   32'h00000000, 32'h3F800002, 32'h3FC00002, 32'h3FA00002,
                                   32'hFF800000, 32'h80000000, 32'hFF800000};
  logic        dir_nan [N_DIR] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
                                   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  // Exact integer product rounded to 24 significant bits, ties to even.
  function automatic logic [32:0] refMul(input logic [31:0] a, input logic [31:0] b);
    int ea, eb, e, sh;
    logic [22:0] fa, fb;
    logic sign;
    bit a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    longint unsigned p, q, rem, half;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    fa = a[22:0];
    fb = b[22:0];
    sign = a[31] ^ b[31];
    a_nan = (ea == 255) && (fa != 0);
    b_nan = (eb == 255) && (fb != 0);
    a_inf = (ea == 255) && (fa == 0);
    b_inf = (eb == 255) && (fb == 0);
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return {1'b1, 32'h7FC00000};
    if (a_inf || b_inf) return {1'b0, sign, 8'hFF, 23'd0};
    if (a_zero || b_zero) return {1'b0, sign, 31'd0};
    p = 64'({1'b1, fa}) * 64'({1'b1, fb});
    sh = (p >= (64'd1 << 47)) ? 24 : 23;
    q = p >> sh;
    rem = p - (q << sh);
    half = 64'd1 << (sh - 1);
    e = ea + eb - 127 + (sh - 23);
    if (rem > half || (rem == half && q[0])) q = q + 1;
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) return {1'b0, sign, 8'hFF, 23'd0};
    if (e <= 0) return {1'b0, sign, 31'd0};
    return {1'b0, sign, e[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] rand_operand();
    int kind;
    logic [22:0] frac;
    logic [7:0] e;
    logic sign;
    kind = $urandom_range(0, 11);
    frac = 23'($urandom());
    sign = 1'($urandom());
    case (kind)
      0: e = 8'd0;
      1: begin e = 8'hFF; frac = '0; end
      2: begin e = 8'hFF; frac[0] = 1'b1; end
      3: e = 8'($urandom_range(200, 254));
      4: e = 8'($urandom_range(1, 60));
      default: e = 8'($urandom_range(90, 165));
    endcase
    return {sign, e, frac};
  endfunction

  // One operation: Ready must stay low for three cycles, pulse in the fourth,
  // and the previous result must hold meanwhile.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic [32:0] expected, input string tag);
    @(negedge clk);
    A = a;
    B = b;
    En = 1'b1;
    @(negedge clk);
    En = 1'b0;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (cyc < 4) begin
        checkOutput({tag, "_ready_early"}, 32'(Ready), 32'd0);
        if (cyc == 2) checkOutput({tag, "_hold"}, Result, last_result);
      end else begin
        checkOutput({tag, "_ready"}, 32'(Ready), 32'd1);
        checkOutput({tag, "_result"}, Result, expected[31:0]);
        checkOutput({tag, "_nan"}, 32'(NaN), 32'(expected[32]));
      end
    end
    last_result = expected[31:0];
  endtask

  initial begin
    int pulses, first_pulse, second_pulse;
    logic [31:0] ra, rb;
    reset = 1'b0;
    En = 1'b0;
    A = '0;
    B = '0;
    last_result = '0;

    repeat (2) @(negedge clk);
    checkOutput("reset_result", Result, 32'd0);
    checkOutput("reset_ready", 32'(Ready), 32'd0);
    checkOutput("reset_nan", 32'(NaN), 32'd0);
    reset = 1'b1;

    for (int i = 0; i < N_DIR; i++)
      applyStimulus(dir_a[i], dir_b[i], {dir_nan[i], dir_res[i]}, $sformatf("dir%0d", i));

    for (int i = 0; i < 40; i++) begin
      ra = rand_operand();
      rb = rand_operand();
      applyStimulus(ra, rb, refMul(ra, rb), $sformatf("rnd%0d_%h_%h", i, ra, rb));
    end

    // En held for two edges starts exactly one operation.
    @(negedge clk);
    A = 32'h40400000;
    B = 32'hBFA00000;
    En = 1'b1;
    pulses = 0;
    first_pulse = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 2) En = 1'b0;
      if (Ready) begin
        pulses++;
        if (first_pulse == 0) first_pulse = i;
      end
    end
    checkOutput("en2_pulses", 32'(pulses), 32'd1);
    checkOutput("en2_latency", 32'(first_pulse), 32'd4);
    checkOutput("en2_result", Result, 32'hC0700000);

    // En held continuously restarts from IDLE: one result per five cycles.
    @(negedge clk);
    A = 32'hBFC00000;
    B = 32'hC0000000;
    En = 1'b1;
    pulses = 0;
    first_pulse = 0;
    second_pulse = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 9) En = 1'b0;
      if (Ready) begin
        pulses++;
        if (first_pulse == 0) first_pulse = i;
        else second_pulse = i;
      end
    end
    checkOutput("b2b_pulses", 32'(pulses), 32'd2);
    checkOutput("b2b_first", 32'(first_pulse), 32'd4);
    checkOutput("b2b_second", 32'(second_pulse), 32'd9);
    checkOutput("b2b_result", Result, 32'h40400000);
    last_result = 32'h40400000;

    // Reset while the operation sits in NORM aborts it silently.
    applyStimulus(32'h7F800000, 32'h00000000, {1'b1, 32'h7FC00000}, "pre_abort");
    @(negedge clk);
    A = 32'h3FC00000;
    B = 32'h40200000;
    En = 1'b1;
    @(negedge clk);
    En = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("abort_result", Result, 32'd0);
    checkOutput("abort_ready", 32'(Ready), 32'd0);
    checkOutput("abort_nan", 32'(NaN), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (Ready) pulses++;
    end
    checkOutput("abort_no_ready", 32'(pulses), 32'd0);
    last_result = '0;
    applyStimulus(32'h3FC00000, 32'h40200000, {1'b0, 32'h40700000}, "post_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
